clk_div_multi: RTL
==================

Name: clk_div_multi

Overview:
- Parametrised, multi-channel successor to the single fixed-ratio divider: NUM_CH independent dividers from one input clock.
- Each channel has a runtime-programmable divisor, a per-channel enable, a near-50% duty divided output and a single-cycle tick strobe.
- Divisor changes are staged and applied only at a period boundary, so outputs stay glitch-free.
- Feeds display scan, debounce and LED-blink logic elsewhere in the design.

Parameters:
- NUM_CH, 4, number of divider channels (1..16).
- WIDTH, 32, counter and divisor width in bits.
- DEFAULT_DIV, 50000000, divisor loaded into every channel at reset (1 Hz at 50 MHz).
- SEL_W, $clog2(NUM_CH) min 1, width of the channel select.

Ports:
- clk_in  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  NUM_CH  per-channel run enable.
- div_load  input  1  one-cycle strobe; stage div_in for channel div_sel.
- div_sel  input  SEL_W  target channel of div_load.
- div_in  input  WIDTH  new divisor value D.
- div_busy  output  NUM_CH  staged divisor not yet applied, per channel.
- clk_out  output  NUM_CH  divided clock, registered.
- tick  output  NUM_CH  one-cycle pulse once per divided period, registered.

Behaviour:
- Per channel: active divisor D, counter cnt (WIDTH bits), pending register, pending-valid flag.
- Reset (rst=1 at an edge):
  - cnt=0, D=DEFAULT_DIV, pending-valid=0.
  - clk_out=0, tick=0, div_busy=0.
  - Reset mid-period or with a pending load discards everything and restarts at cnt=0.
- Counting (en=1):
  - cnt counts 0,1,...,D-1 then wraps to 0. Period is exactly D cycles.
- Outputs, registered from the current cnt (one-cycle latency):
  - clk_out <= (cnt < (D>>1)). High for floor(D/2) cycles, low for ceil(D/2).
  - tick <= (cnt == D-1).
- Enable low (en=0):
  - cnt and clk_out hold their values; tick <= 0.
  - Counting resumes from the held cnt when en returns to 1.
- Divisor load, on an edge with div_load=1:
  - If div_sel < NUM_CH: pending <= div_in, pending-valid <= 1, div_busy <= 1.
  - If div_sel >= NUM_CH: ignored.
  - A load while busy overwrites pending; last write wins.
- Apply, on the wrap edge (en=1, cnt==D-1):
  - If pending-valid: D <= pending, pending-valid <= 0, div_busy <= 0.
  - cnt <= 0 as usual.
- Simultaneous events:
  - Load on the same edge as a wrap: the new value is staged only, and applies at the following wrap. Any previously pending value is applied at this wrap only if no load hits the same channel this edge; the new load supersedes it.
  - rst has priority over div_load and en.
- Clamping: divisor values 0 and 1 are stored as 2, both at stage and at reset if DEFAULT_DIV<2. Minimum period is 2 cycles: clk_out alternates 1,0 and tick fires every 2nd cycle.
- Arithmetic: unsigned; D-1 and D>>1 computed in WIDTH bits. The maximum divisor 2^WIDTH-1 must work with no overflow.
- Channels are fully independent, with no cross-channel phase alignment.

Decomposition:
- Shared package clk_div_pkg: DIV_MIN=2 constant, default WIDTH, and a clamp function for the divisor.
- One sub-module, clk_div_chan: single-channel counter, staging, clamping and outputs.
- Top level: generate loop of NUM_CH instances plus decode of div_sel into per-channel load strobes.

Test Plan:
- Reset with DEFAULT_DIV=4, en=all 1:
  - clk_out[0] = 1,1,0,0 repeating, starting the cycle after the first post-reset edge.
  - tick[0] high exactly 1 of every 4 cycles, one cycle after cnt=3.
- Odd divisor: load D=5 on ch1.
  - div_busy[1] goes 1 and clears at the next wrap.
  - Thereafter clk_out[1] is high 2 cycles, low 3 cycles; tick period is 5.
- Load at the exact wrap cycle, D=4 to 6 on ch0:
  - One more 4-cycle period is observed, then 6-cycle periods.
  - Two back-to-back loads 6 then 8 before the wrap: only 8 applies.
- en[2] dropped for 7 cycles mid-period:
  - clk_out[2] frozen, tick[2]=0 throughout.
  - Remaining period length after re-enable equals the remainder before the drop.
- Load D=0 and D=1: both behave as D=2. Load with div_sel >= NUM_CH (NUM_CH=3): no div_busy change on any channel.
- rst asserted mid-period with a pending load:
  - All outputs 0 next cycle, div_busy=0.
  - DEFAULT_DIV periods resume; the pending value is never applied.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clk_div_pkg;

  // Smallest legal divisor: one high cycle and one low cycle.
  localparam int unsigned DIV_MIN       = 2;
  localparam int unsigned DEFAULT_WIDTH = 32;

  // Width used by the clamp helper. Divisor widths up to this size are supported.
  localparam int unsigned CLAMP_W = 64;

  // Divisors below DIV_MIN would give a zero-length or one-cycle period. Force them to DIV_MIN.
  function automatic logic [CLAMP_W-1:0] clamp_div(input logic [CLAMP_W-1:0] d);
    return (d < CLAMP_W'(DIV_MIN)) ? CLAMP_W'(DIV_MIN) : d;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// Single divider channel: counter, staged divisor, registered clock and tick outputs.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned      WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(50000000)
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] div_in,
  output logic             busy,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(clamp_div(CLAMP_W'(DEFAULT_DIV)));

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;

  logic [WIDTH-1:0] div_last;
  logic [WIDTH-1:0] div_half;
  logic [WIDTH-1:0] div_clamped;
  logic             wrap;

  // div_q >= 2 always, so div_last never underflows and cnt_q + 1 never overflows.
  assign div_last    = div_q - WIDTH'(1);
  assign div_half    = div_q >> 1;
  assign div_clamped = WIDTH'(clamp_div(CLAMP_W'(div_in)));
  assign wrap        = en && (cnt_q == div_last);

  // Next-state: count, derive outputs from the current count, stage and apply divisors.
  always_comb begin
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    clk_out_d  = clk_out_q;
    tick_d     = 1'b0;

    if (en) begin
      cnt_d     = wrap ? '0 : cnt_q + WIDTH'(1);
      clk_out_d = (cnt_q < div_half);
      tick_d    = wrap;
    end

    // A load on the wrap edge supersedes any older pending value; it applies one wrap later.
    if (load) begin
      pend_d     = div_clamped;
      pend_vld_d = 1'b1;
    end else if (wrap && pend_vld_q) begin
      div_d      = pend_q;
      pend_vld_d = 1'b0;
    end
  end

  // State register with synchronous reset; reset drops any staged divisor.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt_q      <= '0;
      div_q      <= RST_DIV;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
    end
  end

  assign busy    = pend_vld_q;
  assign clk_out = clk_out_q;
  assign tick    = tick_q;

endmodule

// File: rtl/clk_div_multi.sv
// NUM_CH independent programmable clock dividers sharing one input clock.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned      NUM_CH      = 4,
  parameter int unsigned      WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(50000000),
  parameter int unsigned      SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              div_load,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [WIDTH-1:0]  div_in,
  output logic [NUM_CH-1:0] div_busy,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic [NUM_CH-1:0] load_vec;

  // Decode the channel select; selects at or above NUM_CH match nothing and are dropped.
  always_comb begin
    load_vec = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      load_vec[i] = div_load && (div_sel == SEL_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    clk_div_chan #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk_in  (clk_in),
      .rst     (rst),
      .en      (en[g]),
      .load    (load_vec[g]),
      .div_in  (div_in),
      .busy    (div_busy[g]),
      .clk_out (clk_out[g]),
      .tick    (tick[g])
    );
  end

endmodule
